// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, FSM state type, twiddle ROM and index
//                bit-reverse helper for the 16-point radix-2 DIT IFFT.
//                Twiddles are W[k] = cos(2*pi*k/16) + j*sin(2*pi*k/16),
//                signed Q1.14 (16384 = 1.0).
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int N       = 16;
    localparam int LOG2N   = 4;
    localparam int DW      = 16;
    localparam int TW      = 16;
    localparam int TW_FRAC = 14;

    // Packed ROM: element k is W[k]; literals listed from k=7 down to k=0.
    localparam logic [7:0][TW-1:0] c_TW_RE = {
        16'(-15137), 16'(-11585), 16'(-6270), 16'(0),
        16'(6270),   16'(11585),  16'(15137), 16'(16384)
    };
    localparam logic [7:0][TW-1:0] c_TW_IM = {
        16'(6270),   16'(11585),  16'(15137), 16'(16384),
        16'(15137),  16'(11585),  16'(6270),  16'(0)
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STAGE = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] rev;
        for (int b = 0; b < LOG2N; b++) begin
            rev[b] = idx[LOG2N-1-b];
        end
        return rev;
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/ifft_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_butterfly
//  Description : Combinational radix-2 DIT butterfly with per-stage halving.
//                t       = (W * bot) >>> 14     (full complex multiply)
//                o_top   = (top + t) >>> 1      (17-bit sum)
//                o_bot   = (top - t) >>> 1
//                Build option IFFT_ROUND_EN: when defined, every shift adds
//                half an LSB first (round-half-up); otherwise shifts floor.
//  Ports       : i_top_re/im, i_bot_re/im - Q1.15 operands
//                i_w_re/im                - Q1.14 twiddle
//                o_top_re/im, o_bot_re/im - scaled results
//  Revision    : 1.0 - initial release
// ============================================================================
module ifft_butterfly
    import fft_pkg::*;
(
    input  logic signed [DW-1:0] i_top_re,
    input  logic signed [DW-1:0] i_top_im,
    input  logic signed [DW-1:0] i_bot_re,
    input  logic signed [DW-1:0] i_bot_im,
    input  logic signed [TW-1:0] i_w_re,
    input  logic signed [TW-1:0] i_w_im,
    output logic signed [DW-1:0] o_top_re,
    output logic signed [DW-1:0] o_top_im,
    output logic signed [DW-1:0] o_bot_re,
    output logic signed [DW-1:0] o_bot_im
);

    localparam int c_PW = DW + TW;

`ifdef IFFT_ROUND_EN
    localparam logic signed [c_PW:0] c_MUL_RND = (c_PW+1)'(2 ** (TW_FRAC - 1));
    localparam logic signed [DW:0]   c_SUM_RND = (DW+1)'(1);
`else
    localparam logic signed [c_PW:0] c_MUL_RND = '0;
    localparam logic signed [DW:0]   c_SUM_RND = '0;
`endif

    logic signed [c_PW:0]  w_acc_re;
    logic signed [c_PW:0]  w_acc_im;
    logic signed [DW-1:0]  w_t_re;
    logic signed [DW-1:0]  w_t_im;
    logic signed [DW:0]    w_sum_re;
    logic signed [DW:0]    w_sum_im;
    logic signed [DW:0]    w_dif_re;
    logic signed [DW:0]    w_dif_im;

    // Accumulate at one bit above the product width so re/im sums cannot wrap.
    assign w_acc_re = (c_PW+1)'(c_PW'(i_w_re) * c_PW'(i_bot_re))
                    - (c_PW+1)'(c_PW'(i_w_im) * c_PW'(i_bot_im)) + c_MUL_RND;
    assign w_acc_im = (c_PW+1)'(c_PW'(i_w_re) * c_PW'(i_bot_im))
                    + (c_PW+1)'(c_PW'(i_w_im) * c_PW'(i_bot_re)) + c_MUL_RND;

    assign w_t_re = DW'(w_acc_re >>> TW_FRAC);
    assign w_t_im = DW'(w_acc_im >>> TW_FRAC);

    assign w_sum_re = (DW+1)'(i_top_re) + (DW+1)'(w_t_re) + c_SUM_RND;
    assign w_sum_im = (DW+1)'(i_top_im) + (DW+1)'(w_t_im) + c_SUM_RND;
    assign w_dif_re = (DW+1)'(i_top_re) - (DW+1)'(w_t_re) + c_SUM_RND;
    assign w_dif_im = (DW+1)'(i_top_im) - (DW+1)'(w_t_im) + c_SUM_RND;

    assign o_top_re = DW'(w_sum_re >>> 1);
    assign o_top_im = DW'(w_sum_im >>> 1);
    assign o_bot_re = DW'(w_dif_re >>> 1);
    assign o_bot_im = DW'(w_dif_im >>> 1);

endmodule : ifft_butterfly
`default_nettype wire

// File: rtl/ifft_16pt.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_16pt
//  Description : 16-point radix-2 DIT inverse FFT, one butterfly per clock,
//                in-place over a 16-entry complex working memory.
//                y[n] = (1/16) * sum_k X[k] * exp(+j*2*pi*k*n/16).
//                Timing: accept at E0, butterflies at E1..E32, y loaded and
//                done raised at E33, done cleared at E34.
//                Build option IFFT_ROUND_EN selects round-half-up shifts.
//  Ports       : clk            - clock, rising edge
//                rst            - synchronous reset, active low
//                start          - request, accepted only in IDLE
//                X_real/X_imag  - 16 x Q1.15 input samples, natural order
//                y_real/y_imag  - 16 x output samples, held until next result
//                busy           - high while butterflies are running
//                done           - one-cycle pulse when y is valid
//  Revision    : 1.0 - initial release
// ============================================================================
module ifft_16pt
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] X_real [0:N-1],
    input  logic signed [DW-1:0] X_imag [0:N-1],
    output logic signed [DW-1:0] y_real [0:N-1],
    output logic signed [DW-1:0] y_imag [0:N-1],
    output logic                 busy,
    output logic                 done
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_stage;
    logic [2:0]           r_bfly;
    logic signed [DW-1:0] r_mem_re [0:N-1];
    logic signed [DW-1:0] r_mem_im [0:N-1];

    logic                 w_last_bfly;
    logic [LOG2N-1:0]     w_top;
    logic [LOG2N-1:0]     w_bot;
    logic [2:0]           w_tw_idx;
    logic signed [TW-1:0] w_tw_re;
    logic signed [TW-1:0] w_tw_im;
    logic signed [DW-1:0] w_out_top_re;
    logic signed [DW-1:0] w_out_top_im;
    logic signed [DW-1:0] w_out_bot_re;
    logic signed [DW-1:0] w_out_bot_im;

    assign w_last_bfly = (r_stage == 2'd3) && (r_bfly == 3'd7);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_STAGE;
            ST_STAGE: if (w_last_bfly) w_state_nxt = ST_OUT;
            ST_OUT:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_STAGE);
    end

    // --------------------------------------------------- butterfly address
    // top = (b >> s) * 2h + (b & (h-1)), twiddle = (b & (h-1)) << (3-s),
    // written out per stage as bit fields.
    always_comb begin
        w_top    = '0;
        w_tw_idx = '0;
        case (r_stage)
            2'd0: begin
                w_top    = {r_bfly, 1'b0};
                w_tw_idx = 3'd0;
            end
            2'd1: begin
                w_top    = {r_bfly[2:1], 1'b0, r_bfly[0]};
                w_tw_idx = {r_bfly[0], 2'b00};
            end
            2'd2: begin
                w_top    = {r_bfly[2], 1'b0, r_bfly[1:0]};
                w_tw_idx = {r_bfly[1:0], 1'b0};
            end
            default: begin
                w_top    = {1'b0, r_bfly};
                w_tw_idx = r_bfly;
            end
        endcase
    end

    assign w_bot   = w_top | (LOG2N'(1) << r_stage);
    assign w_tw_re = c_TW_RE[w_tw_idx];
    assign w_tw_im = c_TW_IM[w_tw_idx];

    ifft_butterfly u_butterfly (
        .i_top_re (r_mem_re[w_top]),
        .i_top_im (r_mem_im[w_top]),
        .i_bot_re (r_mem_re[w_bot]),
        .i_bot_im (r_mem_im[w_bot]),
        .i_w_re   (w_tw_re),
        .i_w_im   (w_tw_im),
        .o_top_re (w_out_top_re),
        .o_top_im (w_out_top_im),
        .o_bot_re (w_out_bot_re),
        .o_bot_im (w_out_bot_im)
    );

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stage <= '0;
            r_bfly  <= '0;
            done    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_mem_re[i] <= '0;
                r_mem_im[i] <= '0;
                y_real[i]   <= '0;
                y_imag[i]   <= '0;
            end
        end else begin
            done <= (r_state == ST_OUT);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_stage <= '0;
                        r_bfly  <= '0;
                        // DIT wants bit-reversed input so output lands in natural order.
                        for (int i = 0; i < N; i++) begin
                            r_mem_re[bit_reverse(LOG2N'(i))] <= X_real[i];
                            r_mem_im[bit_reverse(LOG2N'(i))] <= X_imag[i];
                        end
                    end
                end
                ST_STAGE: begin
                    r_mem_re[w_top] <= w_out_top_re;
                    r_mem_im[w_top] <= w_out_top_im;
                    r_mem_re[w_bot] <= w_out_bot_re;
                    r_mem_im[w_bot] <= w_out_bot_im;
                    r_bfly          <= r_bfly + 3'd1;
                    if (r_bfly == 3'd7) begin
                        r_stage <= r_stage + 2'd1;
                    end
                end
                ST_OUT: begin
                    for (int i = 0; i < N; i++) begin
                        y_real[i] <= r_mem_re[i];
                        y_imag[i] <= r_mem_im[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : ifft_16pt
`default_nettype wire
